// File: rtl/regfile_scoreboard.sv
// Register file with pending-write scoreboard and write-to-read bypass for the decode/writeback stages.
// Latency: reads, RBUSY and ISSUE_OK are combinational; writes, counters and ERR update on the next posedge.
// Backpressure: ISSUE_OK=0 means the reservation is ignored and decode must hold ISSUE_EN/ISSUE_DST.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1,
   parameter int CNT_W  = 2
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [NREAD*ADDR_W-1:0]   IR,
   output logic [NREAD*DATA_W-1:0]   OR,
   output logic [NREAD-1:0]          RBUSY,
   input  logic                      WE,
   input  logic [ADDR_W-1:0]         W,
   input  logic [DATA_W-1:0]         Din,
   input  logic                      ISSUE_EN,
   input  logic [ADDR_W-1:0]         ISSUE_DST,
   output logic                      ISSUE_OK,
   output logic                      ERR,
   output logic [DATA_W-1:0]         a0,
   output logic [DATA_W-1:0]         v0,
   output logic [DATA_W-1:0]         ra
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] reg_q [DEPTH];
   logic [DATA_W-1:0] reg_d [DEPTH];
   logic [CNT_W-1:0]  cnt_q [DEPTH];
   logic [CNT_W-1:0]  cnt_d [DEPTH];
   logic              err_q;
   logic              err_d;

   logic wr_en;       // architectural write (register 0 is never written)
   logic dec;         // writeback retires one pending reservation
   logic issue_acc;   // reservation accepted this cycle
   logic same_reg;    // issue and retire hit the same register: net change is zero

   assign wr_en     = WE && (W != '0);
   assign dec       = wr_en && (cnt_q[W] != '0);
   // A full counter can still take a new reservation when that same register retires one this cycle.
   assign ISSUE_OK  = (ISSUE_DST == '0) || (cnt_q[ISSUE_DST] != CNT_MAX) || (dec && (ISSUE_DST == W));
   assign issue_acc = ISSUE_EN && ISSUE_OK && (ISSUE_DST != '0);
   assign same_reg  = issue_acc && dec && (ISSUE_DST == W);

   // Next-state for register contents, pending counters and the sticky error flag.
   always_comb begin
      reg_d = reg_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (wr_en) begin
         reg_d[W] = Din;
         // Writeback with nothing outstanding is still committed, but flagged.
         if (cnt_q[W] == '0) begin
            err_d = 1'b1;
         end
      end
      if (issue_acc && !same_reg) begin
         cnt_d[ISSUE_DST] = cnt_q[ISSUE_DST] + CNT_ONE;
      end
      if (dec && !same_reg) begin
         cnt_d[W] = cnt_q[W] - CNT_ONE;
      end
      reg_d[0] = '0;
      cnt_d[0] = '0;
   end

   // State registers; reset wins over any write or issue in the same cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            reg_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         reg_q <= reg_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Independent read ports with optional same-cycle forwarding of writeback data.
   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      logic              fwd;
      assign rd_addr = IR[g*ADDR_W +: ADDR_W];
      assign fwd     = (BYPASS != 0) && WE && (W == rd_addr);
      assign OR[g*DATA_W +: DATA_W] = (rd_addr == '0) ? '0 :
                                      fwd            ? Din : reg_q[rd_addr];
      // Last outstanding write arriving via the bypass makes the register usable now.
      assign RBUSY[g] = (rd_addr != '0) && (cnt_q[rd_addr] != '0) &&
                        !(fwd && (cnt_q[rd_addr] == CNT_ONE));
   end

   assign ERR = err_q;
   assign a0  = reg_q[4];
   assign v0  = reg_q[2];
   assign ra  = reg_q[31];

endmodule
